// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the load/store unit (master)
// and the memory or bus fabric (slave).
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: word/byte accesses over a req/ack bus with lane
// steering, pipeline stall and bus timeout. Optional macro: MEM_ALIGN_CHECK_EN.
module mem_access_unit #(
  parameter int unsigned MAX_WAIT     = 16,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      MemtoRegM,
  input  logic                      MemWriteM,
  input  logic                      ByteM,
  input  logic [31:0]               ALUResultM,
  input  logic [31:0]               WriteDataM,
  output logic [31:0]               ReadDataM,
  output logic                      StallMem,
  output logic                      bus_err,
  output logic                      align_fault,
  mem_access_unit_if.master         bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt;
  logic        is_load;
  logic        is_byte;
  logic [1:0]  lane;
  logic        access;
  logic        misaligned;
  logic        issue, complete, timeout, fault;
  logic [31:0] load_data;

  assign access = MemtoRegM | MemWriteM;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = ~ByteM & (ALUResultM[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    StallMem  = 1'b0;
    issue     = 1'b0;
    complete  = 1'b0;
    timeout   = 1'b0;
    fault     = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          StallMem  = 1'b1;
          issue     = ~misaligned;
          fault     = misaligned;
          state_nxt = misaligned ? DONE : BUSY;
        end
      end
      BUSY: begin
        StallMem = 1'b1;
        if (bus.mem_ack) begin
          complete  = 1'b1;
          state_nxt = DONE;
        end else if (wait_cnt == 8'(MAX_WAIT - 1)) begin
          timeout   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Byte loads return the addressed lane zero-extended.
  always_comb begin
    load_data = bus.mem_rdata;
    if (is_byte) load_data = {24'h0, bus.mem_rdata[{lane, 3'b000} +: 8]};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wait_cnt      <= 8'h0;
      is_load       <= 1'b0;
      is_byte       <= 1'b0;
      lane          <= 2'b00;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 32'h0;
      bus.mem_wdata <= 32'h0;
      bus.mem_be    <= 4'h0;
      ReadDataM     <= 32'h0;
      bus_err       <= 1'b0;
    end else begin
      state   <= state_nxt;
      bus_err <= timeout;

      if (issue) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= MemWriteM;
        bus.mem_addr  <= {ALUResultM[31:2], 2'b00};
        bus.mem_be    <= ByteM ? (4'b0001 << ALUResultM[1:0]) : 4'hF;
        bus.mem_wdata <= ByteM ? {4{WriteDataM[7:0]}} : WriteDataM;
        is_load       <= ~MemWriteM;
        is_byte       <= ByteM;
        lane          <= ALUResultM[1:0];
        wait_cnt      <= 8'h0;
      end else if (state == BUSY) begin
        wait_cnt <= wait_cnt + 8'h1;
      end

      if (complete || timeout) bus.mem_req <= 1'b0;

      // A store sharing the cycle with a load flag never touches ReadDataM.
      if (complete && is_load) ReadDataM <= load_data;
      if (timeout && is_load)  ReadDataM <= TIMEOUT_DATA;
      if (fault && !MemWriteM) ReadDataM <= 32'h0;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) align_fault <= 1'b0;
    else       align_fault <= fault;
  end
`else
  assign align_fault = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// traffic against a byte-level memory reference model; slave memory answers the bus.
module tb_mem_access_unit;

  localparam int MAX_WAIT = 4;
  localparam int NEVER    = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemtoRegM, MemWriteM, ByteM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallMem, bus_err, align_fault;

  mem_access_unit_if bus ();

  mem_access_unit #(.MAX_WAIT(MAX_WAIT), .TIMEOUT_DATA(32'hDEADBEEF)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemtoRegM  (MemtoRegM),
    .MemWriteM  (MemWriteM),
    .ByteM      (ByteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallMem   (StallMem),
    .bus_err    (bus_err),
    .align_fault(align_fault),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] slave_mem [0:255];
  logic [31:0] ref_mem   [0:255];
  logic [31:0] exp_rd;

  typedef struct {
    int          stalls;
    int          busy;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        unstable;
    logic [31:0] rd;
    logic        err;
    logic        af;
    logic        req_done;
    logic        hung;
  } obs_t;

  function automatic logic [31:0] ref_load(logic by, logic [31:0] a);
    logic [31:0] w;
    w = ref_mem[a[9:2]];
    if (by) return (w >> (8 * int'(a[1:0]))) & 32'h0000_00FF;
    return w;
  endfunction

  function automatic void ref_store(logic by, logic [31:0] a, logic [31:0] wd);
    if (by) ref_mem[a[9:2]][8 * int'(a[1:0]) +: 8] = wd[7:0];
    else    ref_mem[a[9:2]] = wd;
  endfunction

  // Presents one access in the IDLE cycle and acts as the bus slave until the
  // unit drops StallMem; observations are returned for the caller to judge.
  task automatic run_access(input logic ld, input logic st, input logic by,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int ack_delay, output obs_t o);
    logic done;
    o = '{default: 0};
    o.hung = 1'b1;
    done = 1'b0;
    @(posedge clk); #1;
    MemtoRegM = ld; MemWriteM = st; ByteM = by; ALUResultM = a; WriteDataM = wd;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        if (o.busy == 0) begin
          o.we = bus.mem_we; o.addr = bus.mem_addr; o.wdata = bus.mem_wdata; o.be = bus.mem_be;
        end else if (bus.mem_we !== o.we || bus.mem_addr !== o.addr ||
                     bus.mem_wdata !== o.wdata || bus.mem_be !== o.be) begin
          o.unstable = 1'b1;
        end
        if (o.busy == ack_delay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = slave_mem[bus.mem_addr[9:2]];
          if (bus.mem_we)
            for (int b = 0; b < 4; b++)
              if (bus.mem_be[b]) slave_mem[bus.mem_addr[9:2]][8*b +: 8] = bus.mem_wdata[8*b +: 8];
        end
        o.busy++;
      end
      #1;
      if (StallMem) begin
        o.stalls++;
        @(posedge clk); #1;
      end else begin
        o.rd = ReadDataM; o.err = bus_err; o.af = align_fault; o.req_done = bus.mem_req;
        o.hung = 1'b0;
        done = 1'b1;
      end
    end
    bus.mem_ack = 1'b0;
    MemtoRegM = 1'b0; MemWriteM = 1'b0; ByteM = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    MemtoRegM = 1'b0; MemWriteM = 1'b0; ByteM = 1'b0; ALUResultM = '0; WriteDataM = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (ReadDataM !== 32'h0) begin n_err++; $display("FAIL rst_rdata got %h want 0", ReadDataM); end
    n_cmp++; if ({bus.mem_req, bus.mem_we, StallMem, bus_err, align_fault} !== 5'b0) begin
      n_err++; $display("FAIL rst_flags got req=%b we=%b stall=%b err=%b af=%b want all 0",
                        bus.mem_req, bus.mem_we, StallMem, bus_err, align_fault);
    end
    n_cmp++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_be} !== 68'h0) begin
      n_err++; $display("FAIL rst_bus got addr=%h wdata=%h be=%h want 0", bus.mem_addr, bus.mem_wdata, bus.mem_be);
    end
    reset = 1'b0;
    exp_rd = 32'h0;
  endtask

  task automatic test_word_store();
    obs_t o;
    run_access(1'b0, 1'b1, 1'b0, 32'h100, 32'h11223344, 0, o);
    ref_store(1'b0, 32'h100, 32'h11223344);
    n_cmp++; if (o.hung) begin n_err++; $display("FAIL ws_done got hung want completion"); end
    n_cmp++; if (o.we !== 1'b1 || o.addr !== 32'h100) begin n_err++; $display("FAIL ws_addr got we=%b addr=%h want 1/00000100", o.we, o.addr); end
    n_cmp++; if (o.be !== 4'hF || o.wdata !== 32'h11223344) begin n_err++; $display("FAIL ws_lanes got be=%h wdata=%h want f/11223344", o.be, o.wdata); end
    n_cmp++; if (o.stalls !== 2) begin n_err++; $display("FAIL ws_stall got %0d want 2", o.stalls); end
    n_cmp++; if (o.req_done !== 1'b0 || o.rd !== exp_rd) begin n_err++; $display("FAIL ws_done_state got req=%b rd=%h want 0/%h", o.req_done, o.rd, exp_rd); end
  endtask

  task automatic test_byte_access();
    obs_t o;
    slave_mem[32'h200 >> 2] = 32'hAABBCCDD;
    ref_mem[32'h200 >> 2]   = 32'hAABBCCDD;
    run_access(1'b1, 1'b0, 1'b1, 32'h203, 32'h0, 0, o);
    exp_rd = ref_load(1'b1, 32'h203);
    n_cmp++; if (o.be !== 4'b1000 || o.addr !== 32'h200 || o.we !== 1'b0) begin
      n_err++; $display("FAIL ldrb_bus got be=%b addr=%h we=%b want 1000/00000200/0", o.be, o.addr, o.we);
    end
    n_cmp++; if (o.rd !== exp_rd) begin n_err++; $display("FAIL ldrb_data got %h want %h", o.rd, exp_rd); end
    run_access(1'b0, 1'b1, 1'b1, 32'h301, 32'h123456EF, 1, o);
    ref_store(1'b1, 32'h301, 32'h123456EF);
    n_cmp++; if (o.be !== 4'b0010 || o.wdata !== 32'hEFEFEFEF || o.we !== 1'b1) begin
      n_err++; $display("FAIL strb_bus got be=%b wdata=%h we=%b want 0010/efefefef/1", o.be, o.wdata, o.we);
    end
    n_cmp++; if (o.stalls !== 3) begin n_err++; $display("FAIL strb_stall got %0d want 3", o.stalls); end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_access(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, NEVER, o);
    exp_rd = 32'hDEADBEEF;
    n_cmp++; if (o.busy !== MAX_WAIT || o.stalls !== MAX_WAIT + 1) begin
      n_err++; $display("FAIL to_cycles got busy=%0d stall=%0d want %0d/%0d", o.busy, o.stalls, MAX_WAIT, MAX_WAIT + 1);
    end
    n_cmp++; if (o.rd !== exp_rd || o.err !== 1'b1 || o.req_done !== 1'b0) begin
      n_err++; $display("FAIL to_done got rd=%h err=%b req=%b want deadbeef/1/0", o.rd, o.err, o.req_done);
    end
    @(posedge clk); #1;
    n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL to_pulse got err=%b want 0", bus_err); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h5555AAAA;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    n_cmp++; if (bus.mem_req !== 1'b0 || StallMem !== 1'b0 || ReadDataM !== exp_rd) begin
      n_err++; $display("FAIL to_stray got req=%b stall=%b rd=%h want 0/0/%h", bus.mem_req, StallMem, ReadDataM, exp_rd);
    end
    // Ack on the final allowed BUSY cycle still completes normally.
    run_access(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, MAX_WAIT - 1, o);
    exp_rd = ref_load(1'b0, 32'h44);
    n_cmp++; if (o.rd !== exp_rd || o.err !== 1'b0 || o.stalls !== MAX_WAIT + 1) begin
      n_err++; $display("FAIL to_edge got rd=%h err=%b stall=%0d want %h/0/%0d", o.rd, o.err, o.stalls, exp_rd, MAX_WAIT + 1);
    end
  endtask

  task automatic test_reset_mid_access();
    obs_t o;
    @(posedge clk); #1;
    MemtoRegM = 1'b1; MemWriteM = 1'b0; ByteM = 1'b0; ALUResultM = 32'h80;
    @(posedge clk); #1;
    n_cmp++; if (bus.mem_req !== 1'b1) begin n_err++; $display("FAIL rm_busy got req=%b want 1", bus.mem_req); end
    @(posedge clk); #1;
    reset = 1'b1; MemtoRegM = 1'b0;
    @(posedge clk); #1;
    exp_rd = 32'h0;
    n_cmp++; if (bus.mem_req !== 1'b0 || StallMem !== 1'b0 || ReadDataM !== exp_rd) begin
      n_err++; $display("FAIL rm_abort got req=%b stall=%b rd=%h want 0/0/0", bus.mem_req, StallMem, ReadDataM);
    end
    reset = 1'b0;
    run_access(1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 0, o);
    exp_rd = ref_load(1'b0, 32'h80);
    n_cmp++; if (o.rd !== exp_rd || o.stalls !== 2) begin
      n_err++; $display("FAIL rm_after got rd=%h stall=%0d want %h/2", o.rd, o.stalls, exp_rd);
    end
  endtask

  task automatic test_align();
    obs_t o;
    slave_mem[32'h400 >> 2] = 32'hCAFEF00D;
    ref_mem[32'h400 >> 2]   = 32'hCAFEF00D;
`ifdef MEM_ALIGN_CHECK_EN
    run_access(1'b1, 1'b0, 1'b0, 32'h402, 32'h0, 0, o);
    exp_rd = 32'h0;
    n_cmp++; if (o.busy !== 0 || o.stalls !== 1) begin n_err++; $display("FAIL al_req got busy=%0d stall=%0d want 0/1", o.busy, o.stalls); end
    n_cmp++; if (o.af !== 1'b1 || o.rd !== exp_rd) begin n_err++; $display("FAIL al_fault got af=%b rd=%h want 1/0", o.af, o.rd); end
    @(posedge clk); #1;
    n_cmp++; if (align_fault !== 1'b0) begin n_err++; $display("FAIL al_pulse got af=%b want 0", align_fault); end
    run_access(1'b0, 1'b1, 1'b0, 32'h401, 32'h01020304, 0, o);
    n_cmp++; if (o.busy !== 0 || o.af !== 1'b1) begin n_err++; $display("FAIL al_store got busy=%0d af=%b want 0/1", o.busy, o.af); end
`else
    run_access(1'b1, 1'b0, 1'b0, 32'h402, 32'h0, 0, o);
    exp_rd = ref_load(1'b0, 32'h400);
    n_cmp++; if (o.addr !== 32'h400 || o.be !== 4'hF) begin n_err++; $display("FAIL al_drop got addr=%h be=%h want 00000400/f", o.addr, o.be); end
    n_cmp++; if (o.rd !== exp_rd || o.af !== 1'b0 || o.stalls !== 2) begin
      n_err++; $display("FAIL al_load got rd=%h af=%b stall=%0d want %h/0/2", o.rd, o.af, o.stalls, exp_rd);
    end
`endif
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    run_access(1'b0, 1'b1, 1'b0, 32'h3F0, 32'h0BADC0DE, 0, o1);
    ref_store(1'b0, 32'h3F0, 32'h0BADC0DE);
    run_access(1'b1, 1'b0, 1'b1, 32'h3F1, 32'h0, 0, o2);
    exp_rd = ref_load(1'b1, 32'h3F1);
    n_cmp++; if (o1.stalls !== 2 || o2.stalls !== 2) begin
      n_err++; $display("FAIL b2b_stall got %0d,%0d want 2,2", o1.stalls, o2.stalls);
    end
    n_cmp++; if (o2.rd !== exp_rd) begin n_err++; $display("FAIL b2b_data got %h want %h", o2.rd, exp_rd); end
  endtask

  task automatic test_random();
    obs_t        o;
    logic        ld, st, by;
    logic [31:0] a, wd, exp_ld;
    int          op, dly, exp_stall, bad;
    logic [3:0]  exp_be;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      op  = int'($urandom_range(1, 3));
      ld  = (op != 2);
      st  = (op != 1);
      by  = 1'($urandom_range(0, 1));
      a   = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
      if (!by) a[1:0] = 2'b00;
      wd  = $urandom;
      dly = (i % 8 == 7) ? NEVER : int'($urandom_range(0, MAX_WAIT - 1));
      exp_ld = ref_load(by, a);
      run_access(ld, st, by, a, wd, dly, o);
      exp_be    = by ? 4'(1 << int'(a[1:0])) : 4'hF;
      exp_stall = (dly == NEVER) ? MAX_WAIT + 1 : dly + 2;
      if (!st && dly == NEVER) exp_rd = 32'hDEADBEEF;
      else if (!st)            exp_rd = exp_ld;
      if (st && dly != NEVER)  ref_store(by, a, wd);
      n_cmp++;
      if (o.hung || o.stalls !== exp_stall || o.err !== (dly == NEVER) || o.rd !== exp_rd ||
          o.we !== st || o.addr !== {a[31:2], 2'b00} || o.be !== exp_be || o.unstable ||
          (st && o.wdata !== (by ? wd[7:0] * 32'h01010101 : wd))) begin
        n_err++; bad++;
        if (bad <= 5)
          $display("FAIL rnd_%0d got stall=%0d err=%b rd=%h we=%b addr=%h be=%h wdata=%h uns=%b want stall=%0d rd=%h addr=%h be=%h",
                   i, o.stalls, o.err, o.rd, o.we, o.addr, o.be, o.wdata, o.unstable, exp_stall, exp_rd, {a[31:2], 2'b00}, exp_be);
      end
    end
    // Sweep every word back through loads is too long; spot-check slave contents instead.
    for (int k = 0; k < 256; k += 17) begin
      n_cmp++;
      if (slave_mem[k] !== ref_mem[k]) begin
        n_err++; $display("FAIL rnd_mem_%0d got %h want %h", k, slave_mem[k], ref_mem[k]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      slave_mem[k] = $urandom;
      ref_mem[k]   = slave_mem[k];
    end
    test_reset();
    test_word_store();
    test_byte_access();
    test_timeout();
    test_reset_mid_access();
    test_align();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
